// File: rtl/iob_bus_arbiter_pkg.sv
// rtl/iob_bus_arbiter_pkg.sv - shared FSM encodings and wait-counter width
package iob_bus_arbiter_pkg;

  localparam int WAIT_W = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/iob_bus_arbiter_rr_select.sv
// rtl/iob_bus_arbiter_rr_select.sv - combinational round-robin pick starting at ptr
module rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/iob_bus_arbiter.sv
// rtl/iob_bus_arbiter.sv - round-robin native-bus arbiter with latched request and slave timeout
module iob_bus_arbiter
  import iob_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic                          timeout
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0]   s_wstrb_q, s_wstrb_d;

  logic [IDX_W-1:0]    sel_idx;
  logic                sel_valid;
  logic                busy, wait_hit, done;

  rr_select #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req    (m_valid),
    .ptr    (ptr_q),
    .winner (sel_idx),
    .valid  (sel_valid)
  );

  // s_ready wins over an expiring wait count, so a late reply is never flagged.
  assign busy     = (state_q == ST_BUSY);
  assign wait_hit = (wait_q == WAIT_LAST);
  assign done     = busy && (s_ready || wait_hit);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    wait_d    = wait_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d   = ST_BUSY;
          grant_d   = sel_idx;
          wait_d    = '0;
          s_addr_d  = m_addr[sel_idx*ADDR_W +: ADDR_W];
          s_wdata_d = m_wdata[sel_idx*DATA_W +: DATA_W];
          s_wstrb_d = m_wstrb[sel_idx*STRB_W +: STRB_W];
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d = ST_IDLE;
          ptr_d   = (int'(grant_q) == N_MASTERS - 1) ? '0 : grant_q + 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    if (done) begin
      m_ready[grant_q] = 1'b1;
    end
    if (busy && s_ready) begin
      m_rdata[grant_q*DATA_W +: DATA_W] = s_rdata;
    end
  end

  assign s_valid = busy;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_wstrb = s_wstrb_q;
  assign timeout = busy && wait_hit && !s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      wait_q    <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wait_q    <= wait_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
    end
  end

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// tb/tb_iob_bus_arbiter.sv - directed vector bench for iob_bus_arbiter
module tb_iob_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            timeout;

  int n_total = 0;
  int n_pass  = 0;

  iob_bus_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mv;
    int          dly;
    logic [31:0] rd;
    int          g;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] addr_of(input int g);
    return (g == 1) ? 32'h200 : 32'h100;
  endfunction

  // One full transaction: request, grant, dly wait cycles, completion, bubble.
  task automatic do_txn(input logic [1:0] mv, input int dly, input logic [31:0] rd, input int g);
    logic [63:0] exp_rdata;
    @(negedge clk);
    m_valid = mv;
    s_ready = 1'b0;
    @(negedge clk);
    chk("s_valid_busy", 64'(s_valid), 64'd1);
    chk("s_addr", 64'(s_addr), 64'(addr_of(g)));
    chk("s_wstrb", 64'(s_wstrb), (g == 1) ? 64'hF : 64'h0);
    for (int i = 0; i < dly; i++) begin
      chk("m_ready_wait", 64'(m_ready), 64'd0);
      @(negedge clk);
    end
    s_ready = 1'b1;
    s_rdata = rd;
    #1;
    exp_rdata = {32'h0, rd} << (32 * g);
    chk("m_ready_done", 64'(m_ready), 64'(2'b01 << g));
    chk("m_rdata_done", 64'(m_rdata), exp_rdata);
    chk("timeout_normal", 64'(timeout), 64'd0);
    @(posedge clk);
    #1;
    s_ready = 1'b0;
    s_rdata = '0;
    chk("bubble_s_valid", 64'(s_valid), 64'd0);
    chk("bubble_m_ready", 64'(m_ready), 64'd0);
  endtask

  initial begin
    rst     = 1'b0;
    m_valid = '0;
    m_addr  = {32'h200, 32'h100};
    m_wdata = {32'h1234, 32'h0};
    m_wstrb = {4'hF, 4'h0};
    s_rdata = '0;
    s_ready = 1'b0;

    vecs[0] = '{2'b11, 0, 32'h1111_1111, 0};
    vecs[1] = '{2'b11, 0, 32'h2222_2222, 1};
    vecs[2] = '{2'b11, 0, 32'h3333_3333, 0};
    vecs[3] = '{2'b11, 0, 32'h4444_4444, 1};
    vecs[4] = '{2'b01, 2, 32'hDEAD_BEEF, 0};
    vecs[5] = '{2'b11, 0, 32'h5555_0001, 1};
    vecs[6] = '{2'b10, 0, 32'h6666_0002, 1};
    vecs[7] = '{2'b10, 1, 32'h7777_0003, 1};
    vecs[8] = '{2'b01, 0, 32'h8888_0004, 0};

    #2 rst = 1'b1;
    #1;
    chk("rst_s_valid", 64'(s_valid), 64'd0);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_s_addr", 64'(s_addr), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_txn(vecs[v].mv, vecs[v].dly, vecs[v].rd, vecs[v].g);
    end

    // Latched write data must hold while the master changes its inputs.
    @(negedge clk);
    m_valid = 2'b01;
    m_wdata[31:0] = 32'hAAAA;
    m_wstrb[3:0]  = 4'hF;
    @(negedge clk);
    chk("stab_wdata_0", 64'(s_wdata), 64'hAAAA);
    m_wdata[31:0] = 32'h5555;
    m_wstrb[3:0]  = 4'h0;
    m_addr[31:0]  = 32'h999;
    @(negedge clk);
    chk("stab_wdata_1", 64'(s_wdata), 64'hAAAA);
    chk("stab_wstrb", 64'(s_wstrb), 64'hF);
    chk("stab_addr", 64'(s_addr), 64'h100);
    s_ready = 1'b1;
    #1 chk("stab_m_ready", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1 s_ready = 1'b0;
    m_addr[31:0] = 32'h100;

    // Slave never answers: abort on the TIMEOUT-th busy cycle.
    @(negedge clk);
    m_valid = 2'b01;
    s_rdata = 32'h1234_5678;
    @(negedge clk);
    for (int i = 1; i < TO; i++) begin
      chk("to_early_timeout", 64'(timeout), 64'd0);
      chk("to_early_m_ready", 64'(m_ready), 64'd0);
      @(negedge clk);
    end
    chk("to_pulse", 64'(timeout), 64'd1);
    chk("to_m_ready", 64'(m_ready), 64'd1);
    chk("to_m_rdata", 64'(m_rdata), 64'd0);
    @(posedge clk);
    #1;
    chk("to_idle", 64'(s_valid), 64'd0);
    chk("to_cleared", 64'(timeout), 64'd0);

    // s_ready lands exactly on the last wait count: normal completion.
    @(negedge clk);
    m_valid = 2'b01;
    @(negedge clk);
    for (int i = 1; i < TO; i++) @(negedge clk);
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    #1;
    chk("coin_timeout", 64'(timeout), 64'd0);
    chk("coin_m_ready", 64'(m_ready), 64'd1);
    chk("coin_m_rdata", 64'(m_rdata), 64'hCAFE_F00D);
    @(posedge clk);
    #1 s_ready = 1'b0;
    s_rdata = '0;

    // Reset mid-busy with master 1 requesting.
    @(negedge clk);
    m_valid = 2'b10;
    @(negedge clk);
    chk("rb_s_valid", 64'(s_valid), 64'd1);
    chk("rb_s_addr", 64'(s_addr), 64'h200);
    #1 rst = 1'b1;
    #1;
    chk("rb_async_s_valid", 64'(s_valid), 64'd0);
    chk("rb_async_m_ready", 64'(m_ready), 64'd0);
    chk("rb_async_s_addr", 64'(s_addr), 64'd0);
    @(negedge clk);
    chk("rb_hold_m_ready", 64'(m_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rb_regrant_valid", 64'(s_valid), 64'd1);
    chk("rb_regrant_addr", 64'(s_addr), 64'h200);
    s_ready = 1'b1;
    #1 chk("rb_regrant_ready", 64'(m_ready), 64'b10);
    @(posedge clk);
    #1 s_ready = 1'b0;

    // Reset clears ptr: with both requesting, master 0 wins after release.
    do_txn(2'b01, 0, 32'h0BAD_0001, 0);
    @(negedge clk);
    m_valid = 2'b11;
    @(negedge clk);
    chk("rp_pre_addr", 64'(s_addr), 64'h200);
    #1 rst = 1'b1;
    #1 chk("rp_m_ready", 64'(m_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rp_post_addr", 64'(s_addr), 64'h100);
    s_ready = 1'b1;
    #1 chk("rp_post_ready", 64'(m_ready), 64'b01);
    @(posedge clk);
    #1 s_ready = 1'b0;
    m_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
